// File: rtl/instruction_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_prefetch
//  Description : Fetches instruction words from CS:fetch_address into a small
//                byte FIFO ahead of the decoder. The fetch pointer is reloaded
//                and the FIFO flushed whenever the IP is rewritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_prefetch #(
    parameter int FIFO_DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
    output logic        mem_access,
    input  logic        mem_ack,
    output logic [18:0] mem_address,
    input  logic [15:0] mem_data,
    output logic [7:0]  fetch_byte,
    output logic        fetch_valid,
    input  logic        fetch_ready
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_address_q, fetch_address_d;
    logic          discard_q, discard_d;
    logic [18:0]   mem_address_q, mem_address_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic          w_pop;
    logic [1:0]    w_push_n;
    logic [7:0]    w_push_b0;
    logic [7:0]    w_push_b1;
    logic [CW:0]   w_free_after_pop;
    logic [18:0]   w_word_addr;
    logic [PW-1:0] w_wr_idx0;
    logic [PW-1:0] w_wr_idx1;

    // Ring-buffer index arithmetic; depth need not be a power of two.
    function automatic logic [PW-1:0] ring_add(input logic [PW-1:0] base,
                                               input logic [CW-1:0] off);
        logic [CW:0] sum;
        sum = (CW + 1)'(base) + {1'b0, off};
        if (sum >= DEPTH_W) begin
            sum = sum - DEPTH_W;
        end
        return PW'(sum);
    endfunction

    assign w_pop            = fetch_valid & fetch_ready;
    assign w_free_after_pop = DEPTH_W - {1'b0, count_q} + {{CW{1'b0}}, w_pop};
    // Word address = ({cs,4'b0} + offset) >> 1; bit 0 of the offset never
    // carries because the segment contributes zeros in the low nibble.
    assign w_word_addr      = {cs, 3'b000} + {4'b0000, fetch_address_q[15:1]};
    assign w_wr_idx0        = ring_add(head_q, count_q);
    assign w_wr_idx1        = ring_add(head_q, count_q + CW'(1));

    assign mem_access  = (state_q == FETCH);
    assign mem_address = mem_address_q;
    assign fetch_valid = (count_q != '0);
    assign fetch_byte  = fifo_q[head_q];

    // Next-state: request sequencing, byte extraction, pointer and FIFO update.
    always_comb begin
        state_d         = state_q;
        fetch_address_d = fetch_address_q;
        discard_d       = discard_q;
        mem_address_d   = mem_address_q;
        head_d          = head_q;
        count_d         = count_q;
        w_push_n        = 2'd0;
        w_push_b0       = 8'h00;
        w_push_b1       = 8'h00;

        case (state_q)
            IDLE: begin
                if (!load_new_ip && (w_free_after_pop >= (CW + 1)'(2))) begin
                    state_d       = FETCH;
                    mem_address_d = w_word_addr;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !load_new_ip) begin
                        if (fetch_address_q[0]) begin
                            w_push_n        = 2'd1;
                            w_push_b0       = mem_data[15:8];
                            fetch_address_d = fetch_address_q + 16'd1;
                        end else begin
                            w_push_n        = 2'd2;
                            w_push_b0       = mem_data[7:0];
                            w_push_b1       = mem_data[15:8];
                            fetch_address_d = fetch_address_q + 16'd2;
                        end
                    end
                end else if (load_new_ip) begin
                    // Bus cycle cannot be cancelled; drop its data when it lands.
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_new_ip) begin
            fetch_address_d = new_ip;
            head_d          = '0;
            count_d         = '0;
            w_push_n        = 2'd0;
        end else begin
            if (w_pop) begin
                head_d = ring_add(head_q, CW'(1));
            end
            count_d = count_q + CW'(w_push_n) - CW'(w_pop);
        end
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            fetch_address_q <= 16'h0000;
            discard_q       <= 1'b0;
            mem_address_q   <= 19'h00000;
            count_q         <= '0;
            head_q          <= '0;
        end else begin
            state_q         <= state_d;
            fetch_address_q <= fetch_address_d;
            discard_q       <= discard_d;
            mem_address_q   <= mem_address_d;
            count_q         <= count_d;
            head_q          <= head_d;
        end
    end

    // FIFO storage: up to two bytes written at the tail per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            if (w_push_n != 2'd0) begin
                fifo_q[w_wr_idx0] <= w_push_b0;
            end
            if (w_push_n == 2'd2) begin
                fifo_q[w_wr_idx1] <= w_push_b1;
            end
        end
    end

endmodule
`default_nettype wire
